shrink: RTL
===========

SHRINK -- requirements
Module: shrink

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flip-flops on input w (legal 2..4).
REQ-002 Parameter MIN_W, default 4, minimum qualifying high width of w in clocks (legal 2..MAX_W-1).
REQ-003 Parameter MAX_W, default 64, high width of w in clocks at which the input is declared stuck.
REQ-004 Parameter CW, default 8, width of the qualified-pulse counter.
REQ-005 Port c  input  1  clock; all flops sample on the rising edge.
REQ-006 Port r  input  1  reset, asynchronous, active-high.
REQ-007 Port w  input  1  stretched pulse, asynchronous to c, nominally 16 clocks wide.
REQ-008 Port clr  input  1  synchronous clear of cnt and stuck.
REQ-009 Port n  output  1  registered single-cycle pulse, one per qualified w pulse.
REQ-010 Port runt  output  1  registered single-cycle pulse, one per rejected short w pulse.
REQ-011 Port stuck  output  1  sticky flag: w held high for MAX_W clocks or more.
REQ-012 Port cnt  output  CW  count of qualified pulses, wraps modulo 2^CW.

Function
REQ-013 w passes through SYNC_STAGES flops; ws is the last stage output; the FSM uses only ws.
REQ-014 FSM states: IDLE, QUAL, HOLD, STUCK; high-width counter hcnt saturates at MAX_W-1.
REQ-015 IDLE: ws=1 -> QUAL with hcnt=1; ws=0 -> stay in IDLE.
REQ-016 QUAL: ws=1 and hcnt<MIN_W-1 -> increment hcnt; ws=1 and hcnt=MIN_W-1 -> assert n for the next cycle, increment cnt, go to HOLD.
REQ-017 QUAL: ws=0 -> assert runt for the next cycle, go to IDLE, cnt unchanged.
REQ-018 HOLD: ws=0 -> IDLE; ws=1 -> increment hcnt; ws=1 and hcnt=MAX_W-1 -> STUCK with stuck set.
REQ-019 STUCK: ws=0 -> IDLE; no n or runt is issued until ws has been low for at least one cycle.
REQ-020 Latency: if w is first sampled high at edge k and held for at least MIN_W clocks, n is high only in the cycle after edge k+SYNC_STAGES+MIN_W-1.
REQ-021 A w pulse exactly MIN_W clocks wide qualifies; a pulse MIN_W-1 clocks wide produces runt.
REQ-022 A single low cycle on ws between two high periods ends the current pulse; the next high period is a new pulse.
REQ-023 n and runt are never high in the same cycle; each is high for at most one cycle per w pulse.
REQ-024 cnt wraps from 2^CW-1 to 0 with no flag.
REQ-025 clr in the same cycle as a cnt increment loads cnt with 1; otherwise clr loads cnt with 0. clr clears stuck unless STUCK is being entered in that cycle.

Reset
REQ-026 While r=1: all synchronizer flops=0, FSM=IDLE, hcnt=0, n=0, runt=0, stuck=0, cnt=0.
REQ-027 Reset in mid-pulse discards the pulse; if w is still high after r falls, it is treated as a new rising edge and is qualified normally.

Configuration
REQ-028 Macro SHRINK_STUCK_EN defined: STUCK state, MAX_W detection and the stuck flag are built as specified.
REQ-029 Macro SHRINK_STUCK_EN undefined: the STUCK state is absent, stuck is tied to 0, HOLD waits on ws=0 for any length of time, and MAX_W is ignored.

Structure
REQ-030 Package shrink_pkg holds the FSM state enum and the default parameter constants (SYNC_STAGES, MIN_W, MAX_W, CW).
REQ-031 The synchronizer is a separate sub-module, pulse_sync, parameterised by stage count, with async active-high reset to 0.

Verification
REQ-032 Defaults; w high at edges 10..25 (16 clocks) -> n high only after edge 15, cnt 0->1, runt=0.
REQ-033 Defaults; w high at edges 10..12 (3 clocks) -> runt high only after edge 15, n=0, cnt unchanged.
REQ-034 Defaults; three 16-clock pulses separated by 1-clock low gaps -> exactly three n pulses, cnt=3.
REQ-035 SHRINK_STUCK_EN defined; w held high 100 clocks -> one n, then stuck=1; clr -> stuck=0; w low then 16-clock pulse -> n issued. Without the macro, same stimulus -> stuck stays 0.
REQ-036 CW=2; five qualified pulses -> cnt sequence 1,2,3,0,1; clr coinciding with 5th n -> cnt=1.
REQ-037 r pulsed at edge 14 during a 16-clock pulse -> no n from that pulse; the remaining high is requalified, n after edge k'+5, where k' is the first sampling edge after r falls.

Source files
------------

// File: rtl/shrink_pkg.sv
// Shared constants and FSM state type for the shrink pulse qualifier.
// The STUCK state exists only when SHRINK_STUCK_EN is defined.
package shrink_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_W       = 4;
  localparam int DEF_MAX_W       = 64;
  localparam int DEF_CW          = 8;

`ifdef SHRINK_STUCK_EN
  typedef enum logic [1:0] {IDLE, QUAL, HOLD, STUCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;
`endif

endpackage

// File: rtl/shrink_pulse_sync.sv
// Multi-stage synchronizer for one asynchronous input, reset to 0.
module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/shrink.sv
// Qualifies stretched pulses on w by high width: long enough -> n, too short -> runt.
// SHRINK_STUCK_EN adds stuck-high detection at MAX_W clocks (STUCK state, stuck flag).
//
// state | meaning
// IDLE  | waiting for ws to rise
// QUAL  | ws high, counting towards MIN_W
// HOLD  | pulse qualified, waiting for ws to fall
// STUCK | ws high for MAX_W clocks, waiting for ws to fall
module shrink
  import shrink_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_W       = DEF_MIN_W,
  parameter int MAX_W       = DEF_MAX_W,
  parameter int CW          = DEF_CW
) (
  input  logic          c,
  input  logic          r,
  input  logic          w,
  input  logic          clr,
  output logic          n,
  output logic          runt,
  output logic          stuck,
  output logic [CW-1:0] cnt
);

  localparam int HW = $clog2(MAX_W);
  localparam logic [HW-1:0] MIN_LAST = HW'(MIN_W - 1);
`ifdef SHRINK_STUCK_EN
  localparam logic [HW-1:0] MAX_LAST = HW'(MAX_W - 1);
`endif

  logic          ws;
  state_t        state, state_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic          n_nx, runt_nx, inc;
`ifdef SHRINK_STUCK_EN
  logic          stuck_set;
`endif

  pulse_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (c),
    .rst     (r),
    .d       (w),
    .q       (ws)
  );

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state <= IDLE;
      hcnt  <= '0;
      n     <= 1'b0;
      runt  <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
      n     <= n_nx;
      runt  <= runt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    n_nx     = 1'b0;
    runt_nx  = 1'b0;
    inc      = 1'b0;
`ifdef SHRINK_STUCK_EN
    stuck_set = 1'b0;
`endif
    case (state)
      IDLE: if (ws) begin
        state_nx = QUAL;
        hcnt_nx  = HW'(1);
      end
      QUAL: if (!ws) begin
        state_nx = IDLE;
        hcnt_nx  = '0;
        runt_nx  = 1'b1;
      end else if (hcnt == MIN_LAST) begin
        state_nx = HOLD;
        hcnt_nx  = hcnt + HW'(1);
        n_nx     = 1'b1;
        inc      = 1'b1;
      end else begin
        hcnt_nx  = hcnt + HW'(1);
      end
      HOLD: if (!ws) begin
        state_nx = IDLE;
        hcnt_nx  = '0;
      end
`ifdef SHRINK_STUCK_EN
      else if (hcnt == MAX_LAST) begin
        state_nx  = STUCK;
        stuck_set = 1'b1;
      end else begin
        hcnt_nx   = hcnt + HW'(1);
      end
      STUCK: if (!ws) begin
        state_nx = IDLE;
        hcnt_nx  = '0;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // A clear that lands on an increment still counts that pulse.
  always_ff @(posedge c or posedge r) begin
    if (r)        cnt <= '0;
    else if (clr) cnt <= inc ? CW'(1) : '0;
    else if (inc) cnt <= cnt + CW'(1);
  end

`ifdef SHRINK_STUCK_EN
  always_ff @(posedge c or posedge r) begin
    if (r)              stuck <= 1'b0;
    else if (stuck_set) stuck <= 1'b1;
    else if (clr)       stuck <= 1'b0;
  end
`else
  assign stuck = 1'b0;
`endif

endmodule
